// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches to a
// variable-latency in-order memory, and buffers returned words for the decoder.
module instr_fetch_unit #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter int               BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      opcode,
  output logic [1:0]      dbg_state
);

  localparam int          CW      = $clog2(BUF_DEPTH + 1);
  localparam int          PW      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_live;
  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_count, r_outstanding, r_discard;
  logic [CW-1:0]   w_out_nxt, w_discard_nxt;
  logic [PW-1:0]   r_rd_ptr, r_wr_ptr, r_tag_rd, r_tag_wr;
  logic [31:0]     r_buf_instr [BUF_DEPTH];
  logic [XLEN-1:0] r_buf_pc    [BUF_DEPTH];
  logic [XLEN-1:0] r_tag       [BUF_DEPTH];
  logic [CW:0]     w_inflight;
  logic            w_accept, w_resp, w_write, w_pop;
  logic            w_unused_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Both handshakes are plain valid/ready: a transfer happens in exactly the
  // cycle where valid and ready are both high at the rising edge; valid never
  // waits on ready. Memory responses carry no ready and must be taken.
  assign w_inflight = {1'b0, r_count} + {1'b0, r_outstanding};
  assign imem_req   = r_live && (r_state == FETCH) && (w_inflight < DEPTH_W) &&
                      !redirect_valid;
  assign w_accept   = imem_req && imem_ready;
  assign w_resp     = imem_rvalid && (r_outstanding != '0);
  assign w_write    = w_resp && (r_discard == '0) && !redirect_valid;
  assign w_pop      = instr_valid && instr_ready;
  assign w_out_nxt  = r_outstanding + CW'(w_accept) - CW'(w_resp);

  always_comb begin
    w_state_nxt   = r_state;
    w_discard_nxt = r_discard;
    case (r_state)
      FETCH: begin
        if (redirect_valid) begin
          w_discard_nxt = w_out_nxt;
          if (w_out_nxt != '0) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // A redirect here only moves the PC; discard already covers everything in flight.
        if (w_resp) w_discard_nxt = r_discard - 1'b1;
        if (w_resp && (r_discard == CW'(1))) w_state_nxt = FETCH;
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= FETCH;
      r_live        <= 1'b0;
      r_pc          <= {RESET_PC[XLEN-1:2], 2'b00};
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_tag_rd      <= '0;
      r_tag_wr      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_live        <= 1'b1;
      r_discard     <= w_discard_nxt;
      r_outstanding <= w_out_nxt;
      if (redirect_valid)  r_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (w_accept)   r_pc <= r_pc + XLEN'(4);
      if (w_accept) r_tag_wr <= ptr_inc(r_tag_wr);
      if (w_resp)   r_tag_rd <= ptr_inc(r_tag_rd);
      if (redirect_valid) begin
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_write) r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_pop)   r_rd_ptr <= ptr_inc(r_rd_ptr);
        r_count <= r_count + CW'(w_write) - CW'(w_pop);
      end
    end
  end

  // Storage needs no reset: contents are only visible behind r_count.
  always_ff @(posedge clk) begin
    if (w_accept) r_tag[r_tag_wr] <= r_pc;
    if (w_write) begin
      r_buf_instr[r_wr_ptr] <= imem_rdata;
      r_buf_pc[r_wr_ptr]    <= r_tag[r_tag_rd];
    end
  end

  assign instr_valid   = (r_count != '0);
  assign instr         = instr_valid ? r_buf_instr[r_rd_ptr] : NOP;
  assign instr_pc      = instr_valid ? r_buf_pc[r_rd_ptr] : '0;
  assign opcode        = instr[6:0];
  assign imem_addr     = r_pc;
  assign dbg_state     = r_state;
  assign w_unused_bits = ^redirect_pc[1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order variable-latency memory model plus a
// program-stream scoreboard (sequential PCs, restarted at every redirect target).
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [1:0]  ST_FETCH = 2'd0;
  localparam logic [1:0]  ST_DRAIN = 2'd1;

  logic        clk, rst_n;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic [6:0]  opcode;
  logic [1:0]  dbg_state;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .opcode(opcode), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- bench state ----------------
  int checks = 0, failures = 0, cyc = 0, last_del_cyc = 0;
  int ready_pct = 0, iready_pct = 0, lat_min = 1, lat_max = 1;
  bit redir_now = 1'b0;
  logic [31:0] redir_target = '0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] exp_q[$];
  logic [31:0] acc_log[$];
  logic [31:0] del_log[$];
  logic        s_req, s_valid, s_acc;
  logic [31:0] s_addr, s_instr, s_pc;
  logic [6:0]  s_op;
  logic [1:0]  s_state;

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
  } redir_vec_t;
  redir_vec_t tbl[5];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk_ge(input string name, input int got, input int min);
    checks++;
    if (got < min) begin
      failures++;
      $display("FAIL %s: got %0d required at least %0d (cycle %0d)", name, got, min, cyc);
    end
  endtask

  task automatic expire(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- driver ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0; redir_now = 1'b0;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_opcode", {25'b0, opcode}, 32'h13);
    chk("rst_state", {30'b0, dbg_state}, {30'b0, ST_FETCH});
    mq_addr.delete(); mq_due.delete(); acc_log.delete(); del_log.delete();
    exp_q.delete(); exp_q.push_back(RESET_PC);
    @(negedge clk);
    rst_n = 1'b1;
    last_del_cyc = cyc;
  endtask

  // One clock: drive at negedge, sample #1 later, update models, then the edge.
  task automatic step();
    logic [31:0] w;
    @(negedge clk);
    imem_ready     = (int'($urandom_range(0, 99)) < ready_pct);
    instr_ready    = (int'($urandom_range(0, 99)) < iready_pct);
    redirect_valid = redir_now;
    redirect_pc    = redir_target;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid; s_instr = instr;
    s_pc = instr_pc; s_op = opcode; s_state = dbg_state;
    s_acc = s_req && imem_ready;
    if (redirect_valid) chk("req_in_redirect", {31'b0, s_req}, 32'h0);
    if (s_req) chk("addr_align", {30'b0, s_addr[1:0]}, 32'h0);
    if (!s_valid) begin
      chk("empty_instr", s_instr, NOP);
      chk("empty_pc", s_pc, 32'h0);
      chk("empty_opcode", {25'b0, s_op}, 32'h13);
    end
    if (s_valid && instr_ready) begin
      w = mem_word(exp_q[0]);
      chk("instr_pc", s_pc, exp_q[0]);
      chk("instr_word", s_instr, w);
      chk("opcode", {25'b0, s_op}, {25'b0, w[6:0]});
      del_log.push_back(s_pc);
      last_del_cyc = cyc;
      exp_q.push_back(exp_q[0] + 32'd4);
      void'(exp_q.pop_front());
    end
    if (redirect_valid) begin
      exp_q.delete();
      exp_q.push_back({redirect_pc[31:2], 2'b00});
    end
    if (imem_rvalid) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (s_acc) begin
      mq_addr.push_back(s_addr);
      mq_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
      acc_log.push_back(s_addr);
      chk_ge("credit_limit", DEPTH, mq_addr.size());
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic set_mode(input int rp, input int ip, input int lmin, input int lmax);
    ready_pct = rp; iready_pct = ip; lat_min = lmin; lat_max = lmax;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n0;
    bit stop;
    rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

    tbl[0] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
    tbl[1] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
    tbl[2] = '{32'h7FFF_FFFF, 32'h7FFF_FFFC, 32'h8000_0000};
    tbl[3] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0004};
    tbl[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};

    // streaming from reset
    do_reset();
    set_mode(100, 100, 1, 1);
    step(); chk("t1_acc0", {31'b0, s_acc}, 32'h1); chk("t1_addr0", s_addr, 32'h0);
    step(); chk("t1_addr1", s_addr, 32'h4); chk("t1_valid_early", {31'b0, s_valid}, 32'h0);
    step(); chk("t1_valid_lat2", {31'b0, s_valid}, 32'h1); chk("t1_pc_first", s_pc, 32'h0);
    repeat (20) step();
    if (acc_log.size() >= 3) chk("t1_addr2", acc_log[2], 32'h8); else expire("t1_addr2");
    chk_ge("t1_throughput", del_log.size(), 10);

    // decoder stall fills the buffer
    do_reset();
    set_mode(100, 0, 1, 1);
    repeat (8) step();
    chk("t2_accepts", acc_log.size(), 32'd2);
    chk("t2_req_stalled", {31'b0, s_req}, 32'h0);
    chk("t2_head_valid", {31'b0, s_valid}, 32'h1);
    chk("t2_head_pc", s_pc, 32'h0);
    chk("t2_head_word", s_instr, mem_word(32'h0));
    iready_pct = 100;
    for (int i = 0; i < 10 && acc_log.size() < 3; i++) step();
    if (acc_log.size() >= 3) chk("t2_resume_addr", acc_log[2], 32'h8); else expire("t2_resume");
    repeat (4) step();
    if (del_log.size() >= 2) begin
      chk("t2_order0", del_log[0], 32'h0);
      chk("t2_order1", del_log[1], 32'h4);
    end else expire("t2_order");

    // redirect with two requests in flight
    do_reset();
    set_mode(100, 100, 3, 3);
    for (int i = 0; i < 30 && acc_log.size() < 4; i++) step();
    if (acc_log.size() < 4) expire("t3_setup");
    chk("t3_outstanding", mq_addr.size(), 32'd2);
    if (mq_addr.size() == 2) begin
      chk("t3_inflight0", mq_addr[0], 32'h8);
      chk("t3_inflight1", mq_addr[1], 32'hC);
    end
    redir_now = 1'b1; redir_target = 32'h103;
    step(); chk("t3_req_redir", {31'b0, s_req}, 32'h0);
    redir_now = 1'b0;
    step(); chk("t3_drain", {30'b0, s_state}, {30'b0, ST_DRAIN});
    n0 = del_log.size();
    for (int i = 0; i < 20 && !s_acc; i++) step();
    if (s_acc) chk("t3_target_addr", s_addr, 32'h100); else expire("t3_target");
    for (int i = 0; i < 20 && del_log.size() < n0 + 2; i++) step();
    if (del_log.size() >= n0 + 2) begin
      chk("t3_pc0", del_log[n0], 32'h100);
      chk("t3_pc1", del_log[n0+1], 32'h104);
    end else expire("t3_delivery");

    // redirect with full buffer, nothing in flight, same-cycle dequeue
    do_reset();
    set_mode(100, 0, 1, 1);
    repeat (6) step();
    redir_now = 1'b1; redir_target = 32'h200; iready_pct = 100;
    step();
    chk("t4_head_valid", {31'b0, s_valid}, 32'h1);
    chk("t4_head_pc", s_pc, 32'h0);
    redir_now = 1'b0; iready_pct = 0;
    step();
    chk("t4_no_drain", {30'b0, s_state}, {30'b0, ST_FETCH});
    chk("t4_req", {31'b0, s_req}, 32'h1);
    chk("t4_addr", s_addr, 32'h200);
    chk("t4_flushed", {31'b0, s_valid}, 32'h0);

    // redirect in the cycle a response arrives, one more still in flight
    do_reset();
    set_mode(100, 100, 2, 2);
    step(); step();
    chk("t5_accepts", acc_log.size(), 32'd2);
    redir_now = 1'b1; redir_target = 32'h300;
    step();
    redir_now = 1'b0;
    step(); chk("t5_drain", {30'b0, s_state}, {30'b0, ST_DRAIN});
    step();
    chk("t5_fetch", {30'b0, s_state}, {30'b0, ST_FETCH});
    chk("t5_req", {31'b0, s_req}, 32'h1);
    chk("t5_addr", s_addr, 32'h300);
    for (int i = 0; i < 10 && del_log.size() < 1; i++) step();
    if (del_log.size() >= 1) chk("t5_first_pc", del_log[0], 32'h300); else expire("t5_delivery");

    // reset in the middle of a stream
    do_reset();
    set_mode(0, 100, 1, 1);
    redir_now = 1'b1; redir_target = 32'h40;
    step();
    redir_now = 1'b0;
    step(); chk("t6_pc40", s_addr, 32'h40);
    ready_pct = 100;
    step(); step(); step();
    chk("t6_busy", {31'b0, s_valid}, 32'h1);
    do_reset();
    step();
    chk("t6_restart_acc", {31'b0, s_acc}, 32'h1);
    chk("t6_restart_addr", s_addr, RESET_PC);

    // redirect target alignment and PC wrap
    for (int v = 0; v < 5; v++) begin
      set_mode(0, 100, 1, 1);
      for (int i = 0; i < 20 && mq_addr.size() > 0; i++) step();
      if (mq_addr.size() > 0) expire("tbl_idle");
      redir_now = 1'b1; redir_target = tbl[v].target;
      step();
      redir_now = 1'b0; ready_pct = 100;
      step();
      chk("tbl_req", {31'b0, s_req}, 32'h1);
      chk("tbl_addr", s_addr, tbl[v].exp_addr);
      ready_pct = 0;
      step();
      chk("tbl_next_addr", s_addr, tbl[v].exp_next);
    end

    // randomized traffic against the stream model
    n0 = del_log.size();
    last_del_cyc = cyc;
    stop = 1'b0;
    for (int seg = 0; seg < 8 && !stop; seg++) begin
      set_mode(int'($urandom_range(30, 100)), int'($urandom_range(20, 100)), 1,
               int'($urandom_range(1, 4)));
      for (int i = 0; i < 300 && !stop; i++) begin
        redir_now = ($urandom_range(0, 99) < 3);
        redir_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15))
                                                   : $urandom;
        step();
        if (cyc - last_del_cyc > 200) begin
          expire("rand_progress");
          stop = 1'b1;
        end
      end
    end
    redir_now = 1'b0;
    chk_ge("rand_deliveries", del_log.size() - n0, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
